qe_decoder_gen2: RTL
====================

Name: qe_decoder_gen2

Overview:
Parametrised next-generation quadrature decoder channel with a single fully synchronous clock domain; no logic is clocked from decoded pulses.
- Synchronises and glitch-filters external A/B/I.
- Decodes in x1/x2/x4 mode into a COUNT_W-bit signed position.
- Latches position on index and flags illegal transitions.
- Measures step period for speed.
- Sits below the bus-register wrapper of each QE unit; the wrapper maps its config and status registers onto these ports.

Parameters:
- COUNT_W, 32: width of position counter and index latch.
- PERIOD_W, 24: width of period timer and period output.
- SYNC_STAGES, 2: flip-flops per input synchroniser (>=2).
- FILTER_LEN, 3: consecutive equal samples needed before a filtered input changes (>=1).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- async_qe_a / async_qe_b / async_qe_i  in  1  raw encoder pins
- enable  in  1  counting enable
- mode  in  2  0=x1, 1=x2, 2=x4, 3=x4
- flip_ab  in  1  swap A and B after filtering
- index_clear_en  in  1  zero count on index rising edge
- load  in  1  one-cycle strobe: count <= load_value
- load_value  in  COUNT_W  preset value
- error_clear  in  1  clears error
- count  out  COUNT_W  signed position
- index_pos  out  COUNT_W  count captured at last index edge
- index_seen  out  1  sticky; cleared by load
- direction  out  1  1 = forward, last valid step
- step  out  1  one-cycle pulse per counted event
- error  out  1  sticky illegal-transition flag
- period  out  PERIOD_W  clocks between last two same-direction steps
- period_valid  out  1  one-cycle pulse when period updates

Behaviour:
- Reset (reset==0 at posedge clk):
  - All outputs 0, synchroniser and filter flops 0.
  - prev_ab = 00.
  - Reset mid-operation discards all in-flight state.
- Filter: filtered output takes the new value on the cycle after FILTER_LEN consecutive synchronised samples equal it.
- Latency: pin edge to count/step = SYNC_STAGES + FILTER_LEN + 1 clocks (6 with defaults).
- Forward sequence AB: 00->10->11->01->00 (A leads). Reverse is the opposite.
- Each cycle the new AB is compared with prev_ab, and prev_ab is always updated, including when enable==0.
  - Both bits changed: illegal. No step; error <= 1.
  - x4: every legal transition steps.
  - x2: legal transitions where A changed.
  - x1: A rising only. +1 if B==0, -1 if B==1.
- Step:
  - count +/- 1 modulo 2^COUNT_W; wrap is silent.
  - direction updated; step pulses.
- Update priority per cycle:
  1. load
  2. index clear
  3. step
  - A coincident step is discarded under load or index clear.
  - error_clear loses to a same-cycle new error.
- Index: on filtered I rising edge, index_pos <= count value before this cycle's update; index_seen <= 1. If index_clear_en, count <= 0.
- enable==0:
  - count, direction, period hold; step/period_valid stay 0.
  - load still works.
  - Index and error detection suppressed.
- Period timer:
  - Increments every enabled cycle, saturating at 2^PERIOD_W-1.
  - Step in same direction as previous: period <= timer, period_valid pulses, timer <= 1.
  - Step with direction reversal or first step after reset/load: timer <= 1, no pulse.
  - Timer reaching saturation: period <= all-ones and period_valid pulses once (stall indication). No further pulse until the next step.

Optional Feature:
QE_PERIOD_MEASURE_EN.
- Defined: period timer and outputs as above.
- Undefined: no timer logic; period and period_valid tied to 0.

Decomposition:
- Package qe_types:
  - qe_mode_t enum (QE_X1, QE_X2, QE_X4).
  - QE_FWD_SEQ constants.
  - Default parameter constants.
- Sub-module qe_input_filter: SYNC_STAGES synchroniser plus FILTER_LEN stability filter, 1-bit; instantiated three times.

Test Plan:
1. Reset, mode=x4, drive 8 forward steps 20 clocks apart -> count=8, direction=1, 8 step pulses, period=20 after second step onward.
2. mode=x1: one full forward cycle then one reverse cycle -> count 0->1->0; x2 same stimulus -> 0->2->0.
3. 2-clock glitch on A (FILTER_LEN=3) -> no step, count unchanged. Simultaneous A/B toggle held stable -> error=1, count unchanged. error_clear -> error=0.
4. count=1234, index_clear_en=1, I rises -> index_pos=1234, count=0, index_seen=1. Same with index_clear_en=0 -> count keeps counting.
5. load_value=32'hFFFF_FFFF, load, one forward step -> count=0 (wrap). load coincident with step -> count=load_value.
6. PERIOD_W=8, no steps after a valid step -> after 255 clocks period=8'hFF with one period_valid pulse. With macro undefined, period stays 0.

Source files
------------

// File: rtl/qe_types.sv
// Shared types and constants for the qe_decoder_gen2 quadrature channel.
// Mode encoding, forward AB sequence and default parameter values.
package qe_types;

  typedef enum logic [1:0] {
    QE_X1 = 2'd0,
    QE_X2 = 2'd1,
    QE_X4 = 2'd2
  } qe_mode_t;

  // Forward (A leads) sequence of {A,B}: 00 -> 10 -> 11 -> 01 -> 00
  localparam logic [1:0] QE_FWD_SEQ0 = 2'b00;
  localparam logic [1:0] QE_FWD_SEQ1 = 2'b10;
  localparam logic [1:0] QE_FWD_SEQ2 = 2'b11;
  localparam logic [1:0] QE_FWD_SEQ3 = 2'b01;

  localparam int QE_DEF_COUNT_W     = 32;
  localparam int QE_DEF_PERIOD_W    = 24;
  localparam int QE_DEF_SYNC_STAGES = 2;
  localparam int QE_DEF_FILTER_LEN  = 3;

  // Next {A,B} state when moving one step forward.
  function automatic logic [1:0] qe_fwd_next(input logic [1:0] ab);
    logic [1:0] nxt;
    nxt = QE_FWD_SEQ0;
    case (ab)
      QE_FWD_SEQ0: nxt = QE_FWD_SEQ1;
      QE_FWD_SEQ1: nxt = QE_FWD_SEQ2;
      QE_FWD_SEQ2: nxt = QE_FWD_SEQ3;
      default:     nxt = QE_FWD_SEQ0;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/qe_input_filter.sv
// One-bit synchroniser followed by a stability filter.
// The output only changes after FILTER_LEN consecutive equal samples.
module qe_input_filter
  import qe_types::*;
#(
  parameter int SYNC_STAGES = QE_DEF_SYNC_STAGES,
  parameter int FILTER_LEN  = QE_DEF_FILTER_LEN
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic filt_out
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic                   r_filt;
  logic                   w_s;

  assign w_s      = r_sync[SYNC_STAGES-1];
  assign filt_out = r_filt;

  // Shift raw pin through the synchroniser chain.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], async_in};
    end
  end

  // Count consecutive samples that differ from the filtered value.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt  <= '0;
      r_filt <= 1'b0;
    end else if (w_s == r_filt) begin
      r_cnt <= '0;
    end else if (r_cnt == CW'(FILTER_LEN - 1)) begin
      r_filt <= w_s;
      r_cnt  <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/qe_decoder_gen2.sv
// Quadrature decoder channel: filter, x1/x2/x4 decode, index latch, errors.
// Optional period measurement is built when QE_PERIOD_MEASURE_EN is defined.
module qe_decoder_gen2
  import qe_types::*;
#(
  parameter int COUNT_W     = QE_DEF_COUNT_W,
  parameter int PERIOD_W    = QE_DEF_PERIOD_W,
  parameter int SYNC_STAGES = QE_DEF_SYNC_STAGES,
  parameter int FILTER_LEN  = QE_DEF_FILTER_LEN
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       async_qe_a,
  input  logic                       async_qe_b,
  input  logic                       async_qe_i,
  input  logic                       enable,
  input  logic [1:0]                 mode,
  input  logic                       flip_ab,
  input  logic                       index_clear_en,
  input  logic                       load,
  input  logic [COUNT_W-1:0]         load_value,
  input  logic                       error_clear,
  output logic signed [COUNT_W-1:0]  count,
  output logic signed [COUNT_W-1:0]  index_pos,
  output logic                       index_seen,
  output logic                       direction,
  output logic                       step,
  output logic                       error,
  output logic [PERIOD_W-1:0]        period,
  output logic                       period_valid
);

  logic w_a_f;
  logic w_b_f;
  logic w_i;

  qe_input_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILTER_LEN (FILTER_LEN)
  ) u_filt_a (
    .clk     (clk),
    .reset   (reset),
    .async_in(async_qe_a),
    .filt_out(w_a_f)
  );

  qe_input_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILTER_LEN (FILTER_LEN)
  ) u_filt_b (
    .clk     (clk),
    .reset   (reset),
    .async_in(async_qe_b),
    .filt_out(w_b_f)
  );

  qe_input_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILTER_LEN (FILTER_LEN)
  ) u_filt_i (
    .clk     (clk),
    .reset   (reset),
    .async_in(async_qe_i),
    .filt_out(w_i)
  );

  logic [1:0]         r_prev_ab;
  logic               r_prev_i;
  logic [COUNT_W-1:0] r_count;
  logic [COUNT_W-1:0] r_index_pos;
  logic               r_index_seen;
  logic               r_dir;
  logic               r_step;
  logic               r_error;

  logic       w_a;
  logic       w_b;
  logic [1:0] w_ab;
  logic [1:0] w_chg;
  logic       w_illegal;
  logic       w_legal;
  logic       w_fwd;
  logic       w_cnt_ev;
  logic       w_step;
  logic       w_idx;
  logic       w_err;
  logic       w_idx_clr;
  logic       w_take_step;

  assign w_a       = flip_ab ? w_b_f : w_a_f;
  assign w_b       = flip_ab ? w_a_f : w_b_f;
  assign w_ab      = {w_a, w_b};
  assign w_chg     = w_ab ^ r_prev_ab;
  assign w_illegal = &w_chg;
  assign w_legal   = (|w_chg) & ~w_illegal;
  assign w_fwd     = (w_ab == qe_fwd_next(r_prev_ab));

  // Select which legal transitions count for the active resolution.
  always_comb begin
    w_cnt_ev = 1'b0;
    case (mode)
      QE_X1:   w_cnt_ev = w_legal & ~r_prev_ab[1] & w_a;
      QE_X2:   w_cnt_ev = w_legal & w_chg[1];
      default: w_cnt_ev = w_legal;
    endcase
  end

  assign w_step      = enable & w_cnt_ev;
  assign w_idx       = enable & w_i & ~r_prev_i;
  assign w_err       = enable & w_illegal;
  assign w_idx_clr   = w_idx & index_clear_en;
  assign w_take_step = w_step & ~load & ~w_idx_clr;

  // Position, index latch, direction and error bookkeeping.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_prev_ab    <= 2'b00;
      r_prev_i     <= 1'b0;
      r_count      <= '0;
      r_index_pos  <= '0;
      r_index_seen <= 1'b0;
      r_dir        <= 1'b0;
      r_step       <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_prev_ab <= w_ab;
      r_prev_i  <= w_i;
      r_step    <= w_take_step;
      if (load) begin
        r_count <= load_value;
      end else if (w_idx_clr) begin
        r_count <= '0;
      end else if (w_take_step) begin
        r_count <= w_fwd ? r_count + COUNT_W'(1)
                         : r_count - COUNT_W'(1);
      end
      if (w_take_step) begin
        r_dir <= w_fwd;
      end
      if (w_idx) begin
        r_index_pos <= r_count;
      end
      if (load) begin
        r_index_seen <= 1'b0;
      end else if (w_idx) begin
        r_index_seen <= 1'b1;
      end
      if (w_err) begin
        r_error <= 1'b1;
      end else if (error_clear) begin
        r_error <= 1'b0;
      end
    end
  end

  assign count      = r_count;
  assign index_pos  = r_index_pos;
  assign index_seen = r_index_seen;
  assign direction  = r_dir;
  assign step       = r_step;
  assign error      = r_error;

`ifdef QE_PERIOD_MEASURE_EN
  localparam logic [PERIOD_W-1:0] P_MAX    = '1;
  localparam logic [PERIOD_W-1:0] P_MAX_M1 = P_MAX - PERIOD_W'(1);

  logic [PERIOD_W-1:0] r_timer;
  logic [PERIOD_W-1:0] r_period;
  logic                r_pvalid;
  logic                r_have_dir;

  // Step-to-step timer; a stall reports all-ones once until the next step.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_timer    <= '0;
      r_period   <= '0;
      r_pvalid   <= 1'b0;
      r_have_dir <= 1'b0;
    end else begin
      r_pvalid <= 1'b0;
      if (load) begin
        r_have_dir <= 1'b0;
      end else if (w_take_step) begin
        r_have_dir <= 1'b1;
      end
      if (w_take_step) begin
        r_timer <= PERIOD_W'(1);
        if (r_have_dir && (w_fwd == r_dir)) begin
          r_period <= r_timer;
          r_pvalid <= 1'b1;
        end
      end else if (enable && (r_timer != P_MAX)) begin
        r_timer <= r_timer + PERIOD_W'(1);
        if (r_timer == P_MAX_M1) begin
          r_period <= P_MAX;
          r_pvalid <= 1'b1;
        end
      end
    end
  end

  assign period       = r_period;
  assign period_valid = r_pvalid;
`else
  assign period       = '0;
  assign period_valid = 1'b0;
`endif

endmodule
